// File: rtl/key_ascii_queue.sv
// key_ascii_queue: turns PS/2 set-2 key events into ASCII characters and queues them.
//   Make events are translated, with Shift and Caps Lock applied, and pushed into a FIFO.
//   The FIFO is drained by the text logic over a valid/ready handshake.
//   With KEY_REPEAT_EN defined, a held printable key auto-repeats: the first repeat comes
//   REPEAT_DELAY cycles after the make, then one every REPEAT_PERIOD cycles.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   key_down_i          pressed-key bitmap indexed by {extend, code}
//   last_change_i       {extend, code} of the latest event
//   key_valid_i         one-cycle event strobe
//   out_char_o          ASCII at FIFO head (0 when empty)
//   out_valid_o         FIFO non-empty
//   out_ready_i         consumer takes head when out_valid_o & out_ready_i
//   count_o             FIFO occupancy
//   caps_lock_o         Caps Lock toggle state
//   overflow_o          sticky flag: a character was dropped
//   clr_overflow_i      synchronous clear of overflow_o
module key_ascii_queue #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [511:0]             key_down_i,
  input  logic [8:0]               last_change_i,
  input  logic                     key_valid_i,
  output logic [7:0]               out_char_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     caps_lock_o,
  output logic                     overflow_o,
  input  logic                     clr_overflow_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  // Returns {mapped, ascii}; codes with the extend bit set fall through to unmapped.
  function automatic logic [8:0] xlate(input logic [8:0] code, input logic shift,
                                       input logic caps);
    logic [7:0] base;
    logic [8:0] res;
    base = (shift ^ caps) ? 8'h41 : 8'h61;
    res  = 9'h000;
    case (code)
      9'h01C: res = {1'b1, base + 8'd0};
      9'h032: res = {1'b1, base + 8'd1};
      9'h021: res = {1'b1, base + 8'd2};
      9'h023: res = {1'b1, base + 8'd3};
      9'h024: res = {1'b1, base + 8'd4};
      9'h02B: res = {1'b1, base + 8'd5};
      9'h034: res = {1'b1, base + 8'd6};
      9'h033: res = {1'b1, base + 8'd7};
      9'h043: res = {1'b1, base + 8'd8};
      9'h03B: res = {1'b1, base + 8'd9};
      9'h042: res = {1'b1, base + 8'd10};
      9'h04B: res = {1'b1, base + 8'd11};
      9'h03A: res = {1'b1, base + 8'd12};
      9'h031: res = {1'b1, base + 8'd13};
      9'h044: res = {1'b1, base + 8'd14};
      9'h04D: res = {1'b1, base + 8'd15};
      9'h015: res = {1'b1, base + 8'd16};
      9'h02D: res = {1'b1, base + 8'd17};
      9'h01B: res = {1'b1, base + 8'd18};
      9'h02C: res = {1'b1, base + 8'd19};
      9'h03C: res = {1'b1, base + 8'd20};
      9'h02A: res = {1'b1, base + 8'd21};
      9'h01D: res = {1'b1, base + 8'd22};
      9'h022: res = {1'b1, base + 8'd23};
      9'h035: res = {1'b1, base + 8'd24};
      9'h01A: res = {1'b1, base + 8'd25};
      9'h045: res = {1'b1, shift ? 8'h29 : 8'h30};
      9'h016: res = {1'b1, shift ? 8'h21 : 8'h31};
      9'h01E: res = {1'b1, shift ? 8'h40 : 8'h32};
      9'h026: res = {1'b1, shift ? 8'h23 : 8'h33};
      9'h025: res = {1'b1, shift ? 8'h24 : 8'h34};
      9'h02E: res = {1'b1, shift ? 8'h25 : 8'h35};
      9'h036: res = {1'b1, shift ? 8'h5E : 8'h36};
      9'h03D: res = {1'b1, shift ? 8'h26 : 8'h37};
      9'h03E: res = {1'b1, shift ? 8'h2A : 8'h38};
      9'h046: res = {1'b1, shift ? 8'h28 : 8'h39};
      9'h029: res = 9'h120;
      9'h05A: res = 9'h10D;
      9'h066: res = 9'h108;
      9'h00D: res = 9'h109;
      9'h076: res = 9'h11B;
      default: res = 9'h000;
    endcase
    return res;
  endfunction

  logic          shift;
  logic          ev_make;
  logic          caps_make;
  logic [8:0]    make_x;
  logic          make_map;
  logic          caps_lock_q, caps_lock_d;
  logic          overflow_q, overflow_d;
  logic          rpt_tick;
  logic [7:0]    rpt_char;

  assign shift     = key_down_i[9'h012] | key_down_i[9'h059];
  assign ev_make   = key_valid_i & key_down_i[last_change_i];
  assign caps_make = ev_make & (last_change_i == 9'h058);
  assign make_x    = xlate(last_change_i, shift, caps_lock_q);
  assign make_map  = ev_make & make_x[8];

`ifdef KEY_REPEAT_EN
  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

  rpt_state_e  state_q, state_d;
  logic [8:0]  rpt_code_q, rpt_code_d;
  logic [31:0] cnt_q, cnt_d;
  logic [8:0]  rpt_x;
  logic        rpt_held;

  assign rpt_x    = xlate(rpt_code_q, shift, caps_lock_q);
  assign rpt_held = key_down_i[rpt_code_q];
  assign rpt_char = rpt_x[7:0];

  always_comb begin
    state_d    = state_q;
    rpt_code_d = rpt_code_q;
    cnt_d      = cnt_q;
    rpt_tick   = 1'b0;
    if (make_map) begin
      // A fresh make restarts the delay and swallows any tick due this cycle.
      state_d    = StDelay;
      rpt_code_d = last_change_i;
      cnt_d      = '0;
    end else begin
      case (state_q)
        StDelay: begin
          if (!rpt_held) begin
            state_d = StIdle;
          end else if (cnt_q == 32'(REPEAT_DELAY - 1)) begin
            rpt_tick = rpt_x[8];
            cnt_d    = '0;
            state_d  = StRepeat;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StRepeat: begin
          if (!rpt_held) begin
            state_d = StIdle;
          end else if (cnt_q == 32'(REPEAT_PERIOD - 1)) begin
            rpt_tick = rpt_x[8];
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rpt_code_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rpt_code_q <= rpt_code_d;
      cnt_q      <= cnt_d;
    end
  end
`else
  assign rpt_tick = 1'b0;
  assign rpt_char = 8'h00;
`endif

  // FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_req, push_ok, pop, full, drop;
  logic [7:0]    push_char;

  assign full      = (count_q == DepthCnt);
  assign pop       = out_valid_o & out_ready_i;
  assign push_req  = make_map | rpt_tick;
  assign push_char = make_map ? make_x[7:0] : rpt_char;
  // When full, a same-edge pop frees the slot the push lands in.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    if (!push_ok && pop) count_d = count_q - 1'b1;
    caps_lock_d = caps_lock_q ^ caps_make;
    overflow_d  = drop | (overflow_q & ~clr_overflow_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      caps_lock_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      caps_lock_q <= caps_lock_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_char;
  end

  assign out_valid_o = (count_q != '0);
  assign out_char_o  = out_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o     = count_q;
  assign caps_lock_o = caps_lock_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_key_ascii_queue.sv
// Bench for key_ascii_queue: translation table, Caps/Shift, FIFO full/overflow, repeat timing
// (or single-shot when KEY_REPEAT_EN is undefined) and asynchronous reset.
module tb_key_ascii_queue;

  logic         clk;
  logic         rst_n;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic [7:0]   out_char;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   count;
  logic         caps_lock;
  logic         overflow;
  logic         clr_overflow;

  key_ascii_queue #(
    .DEPTH        (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .key_down_i    (key_down),
    .last_change_i (last_change),
    .key_valid_i   (key_valid),
    .out_char_o    (out_char),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .count_o       (count),
    .caps_lock_o   (caps_lock),
    .overflow_o    (overflow),
    .clr_overflow_i(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted head must match the oldest expected character.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no output", out_char);
      end else begin
        e = exp_q.pop_front();
        if (out_char !== e) begin
          errors++;
          $display("FAIL pop_char: got %h, required %h", out_char, e);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key_event(input logic [8:0] code, input logic make);
    key_down[code] = make;
    last_change    = code;
    key_valid      = 1'b1;
    step();
    key_valid      = 1'b0;
  endtask

  typedef struct packed {
    logic [8:0] code;
    logic [1:0] sh;      // 0 none, 1 left shift, 2 right shift
    logic       mapped;
    logic [7:0] ch;
  } vec_t;

  vec_t vecs [16];

  initial begin : timeout
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0]  = '{9'h01C, 2'd0, 1'b1, 8'h61};
    vecs[1]  = '{9'h01C, 2'd1, 1'b1, 8'h41};
    vecs[2]  = '{9'h016, 2'd1, 1'b1, 8'h21};
    vecs[3]  = '{9'h045, 2'd0, 1'b1, 8'h30};
    vecs[4]  = '{9'h045, 2'd2, 1'b1, 8'h29};
    vecs[5]  = '{9'h03D, 2'd1, 1'b1, 8'h26};
    vecs[6]  = '{9'h01A, 2'd0, 1'b1, 8'h7A};
    vecs[7]  = '{9'h029, 2'd0, 1'b1, 8'h20};
    vecs[8]  = '{9'h05A, 2'd0, 1'b1, 8'h0D};
    vecs[9]  = '{9'h066, 2'd0, 1'b1, 8'h08};
    vecs[10] = '{9'h00D, 2'd0, 1'b1, 8'h09};
    vecs[11] = '{9'h076, 2'd0, 1'b1, 8'h1B};
    vecs[12] = '{9'h175, 2'd0, 1'b0, 8'h00};
    vecs[13] = '{9'h005, 2'd0, 1'b0, 8'h00};
    vecs[14] = '{9'h015, 2'd0, 1'b1, 8'h71};
    vecs[15] = '{9'h04D, 2'd2, 1'b1, 8'h50};

    rst_n = 1'b0; key_down = '0; last_change = '0; key_valid = 1'b0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_caps", 32'(caps_lock), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_out_char", 32'(out_char), 0);
    rst_n = 1'b1;
    step();

    // Translation table
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      key_down[9'h012] = (vecs[i].sh == 2'd1);
      key_down[9'h059] = (vecs[i].sh == 2'd2);
      if (vecs[i].mapped) exp_q.push_back(vecs[i].ch);
      key_event(vecs[i].code, 1'b1);
      check($sformatf("vec%0d_count", i), 32'(count), vecs[i].mapped ? 1 : 0);
      key_event(vecs[i].code, 1'b0);
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
      key_down[9'h012] = 1'b0;
      key_down[9'h059] = 1'b0;
    end

    // Caps Lock
    key_event(9'h058, 1'b1);
    check("caps_on", 32'(caps_lock), 1);
    check("caps_no_enqueue", 32'(count), 0);
    key_event(9'h058, 1'b0);
    exp_q.push_back(8'h41);
    key_event(9'h01C, 1'b1);
    key_event(9'h01C, 1'b0);
    key_down[9'h012] = 1'b1;
    exp_q.push_back(8'h61);
    key_event(9'h01C, 1'b1);
    key_event(9'h01C, 1'b0);
    key_down[9'h012] = 1'b0;
    exp_q.push_back(8'h31);
    key_event(9'h016, 1'b1);
    key_event(9'h016, 1'b0);
    key_event(9'h058, 1'b1);
    check("caps_off", 32'(caps_lock), 0);
    key_event(9'h058, 1'b0);

    // Break without make
    key_event(9'h01C, 1'b0);
    check("break_no_enqueue", 32'(count), 0);

    // Full / overflow
    out_ready = 1'b0;
    begin
      logic [8:0] codes [5];
      logic [7:0] chars [5];
      codes = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024};
      chars = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      for (int i = 0; i < 5; i++) begin
        if (i < 4) exp_q.push_back(chars[i]);
        key_event(codes[i], 1'b1);
        key_event(codes[i], 1'b0);
      end
    end
    check("full_count", 32'(count), 4);
    check("full_overflow", 32'(overflow), 1);
    out_ready = 1'b1;
    exp_q.push_back(8'h66);
    key_event(9'h02B, 1'b1);
    out_ready = 1'b0;
    check("full_pushpop_count", 32'(count), 4);
    key_event(9'h02B, 1'b0);
    check("overflow_sticky", 32'(overflow), 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("overflow_cleared", 32'(overflow), 0);
    clr_overflow = 1'b1;
    key_event(9'h02D, 1'b1);
    clr_overflow = 1'b0;
    check("drop_beats_clear", 32'(overflow), 1);
    key_event(9'h02D, 1'b0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_count", 32'(count), 0);
    check("drain_scoreboard", 32'(exp_q.size()), 0);

`ifdef KEY_REPEAT_EN
    // Typematic: 1 make + first repeat at +10 + every 4 through cycle 30
    pop_cyc.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h61);
    key_event(9'h01C, 1'b1);
    repeat (30) step();
    key_event(9'h01C, 1'b0);
    repeat (20) step();
    check("rpt_scoreboard", 32'(exp_q.size()), 0);
    check("rpt_pops", 32'(pop_cyc.size()), 7);
    if (pop_cyc.size() == 7) begin
      check("rpt_first_gap", 32'(pop_cyc[1] - pop_cyc[0]), 10);
      check("rpt_period_span", 32'(pop_cyc[6] - pop_cyc[1]), 20);
    end
`else
    out_ready = 1'b0;
    exp_q.push_back(8'h61);
    key_event(9'h01C, 1'b1);
    repeat (100) step();
    check("hold_single_entry", 32'(count), 1);
    key_event(9'h01C, 1'b0);
    out_ready = 1'b1;
    step();
    check("hold_drained", 32'(count), 0);
`endif

    // Reset mid-operation with a key still held
    out_ready = 1'b0;
    key_event(9'h01C, 1'b1);
    key_event(9'h01C, 1'b0);
    key_event(9'h032, 1'b1);
    key_event(9'h032, 1'b0);
    key_event(9'h021, 1'b1);
    check("pre_reset_count", 32'(count), 3);
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    check("async_reset_count", 32'(count), 0);
    check("async_reset_valid", 32'(out_valid), 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    n = pop_cyc.size();
    repeat (20) step();
    check("post_reset_no_repeat", 32'(count), 0);
    check("post_reset_no_pops", 32'(pop_cyc.size()), 32'(n));
    key_event(9'h021, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_ascii_queue.md
Name: key_ascii_queue

Overview:
- Consumes the keyboard decoder's key-event stream (`key_valid` pulse, 9-bit `{extend, code}` in `last_change`, and the `key_down` bitmap).
- Translates PS/2 set-2 make events into 8-bit ASCII, applying Shift and Caps Lock.
- Generates typematic auto-repeat for held printable keys.
- Buffers the characters in a FIFO read by the text/IDE logic through a valid/ready handshake.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- REPEAT_DELAY, 50000000, clk cycles from make to first repeat.
- REPEAT_PERIOD, 10000000, clk cycles between subsequent repeats.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- key_down  in  512  pressed-key bitmap indexed by `{extend, code}`
- last_change  in  9  `{extend, code}` of the latest event
- key_valid  in  1  one-cycle event strobe
- out_char  out  8  ASCII at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when `out_valid & out_ready`
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- caps_lock  out  1  Caps Lock toggle state
- overflow  out  1  sticky: a character was dropped
- clr_overflow  in  1  synchronous clear of `overflow`

Behaviour:
- Reset (rst=0, async):
  - `out_valid`=0, `count`=0, `caps_lock`=0, `overflow`=0, `out_char`=8'h00.
  - FIFO pointers cleared; repeat FSM to IDLE; counters 0.
  - Reset mid-operation discards all queued characters.
- Event classification, on a clk edge with `key_valid`=1:
  - make if `key_down[last_change]`=1, else break.
  - Break events never enqueue.
- Translation (combinational on the 9-bit code; bit8=1 → unmapped):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
    - Uppercase iff `shift ^ caps_lock`.
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9'.
    - With shift they become `) ! @ # $ % ^ & * (`.
  - Space 29 → 20h; Enter 5A → 0Dh; Backspace 66 → 08h; Tab 0D → 09h; Esc 76 → 1Bh.
  - All other codes are unmapped: no enqueue.
  - `shift = key_down[9'h012] | key_down[9'h059]`.
- Caps Lock: a make of 9'h058 toggles `caps_lock` at that edge, enqueues nothing, and does not affect the repeat FSM.
- Latency: a mapped make sampled at edge E is written at E.
  - `out_valid`/`count` reflect it immediately after E.
  - No combinational path from `key_valid` to outputs.
- FIFO:
  - Pop when `out_valid & out_ready`.
  - Simultaneous push and pop is legal at any occupancy, including full (count unchanged).
  - Push while full without a pop: character dropped, `overflow`←1.
  - `clr_overflow` clears `overflow`; a simultaneous drop wins (stays 1).
  - Pointers wrap modulo DEPTH.
  - `out_char` holds the head entry and is don't-care when empty.
- Repeat FSM (states IDLE, DELAY, REPEAT), with `rpt_code` (9b) and a cycle counter:
  - Any mapped make → load `rpt_code`, counter=0, go to DELAY. This applies from any state, so a new key restarts the delay.
  - DELAY: counter counts up. Reaching REPEAT_DELAY-1 → push translation of `rpt_code` using the current shift/caps, counter=0, go to REPEAT.
  - REPEAT: counter counts up. Reaching REPEAT_PERIOD-1 → push, counter=0.
  - In DELAY or REPEAT, a break of `rpt_code` (or `key_down[rpt_code]`=0) → IDLE; no further pushes.
  - A break of any other key has no effect.
  - Same-edge make and a repeat tick: the make wins and the tick is discarded.
  - Repeat pushes obey the same full/overflow rules.

Optional Feature:
- Macro KEY_REPEAT_EN.
  - Defined: repeat FSM and counters present as above.
  - Undefined: FSM and counter logic omitted; only make events enqueue.
  - All ports are identical in both builds.

Test Plan:
- Reset, then make 1C with no shift and `caps_lock`=0 → next cycle `out_valid`=1, `out_char`=61h, `count`=1. Pop with `out_ready`=1 → `out_valid`=0.
- Hold 012 then make 16 → 21h ('!'). Caps make 058 then make 1C → `caps_lock`=1, 41h. With Shift held, make 1C → 61h.
- With DELAY=10 and PERIOD=4: make 1C, hold 30 cycles → 1 + 1 + floor((30-10)/4)=5 → 7 entries 61h, the 2nd at cycle 10. Break 1C → no more pushes.
- With DEPTH=4 and `out_ready`=0, send 5 makes → `count`=4, `overflow`=1. Push and pop on the same edge while full → `count` stays 4. `clr_overflow` → 0.
- Extended make 1_75 and unmapped 0_05 → no enqueue. Break events → no enqueue.
- Assert rst=0 with 3 queued entries, mid-DELAY → `count`=0, `out_valid`=0, no repeat after release. In a build without KEY_REPEAT_EN, holding a key for 100 cycles → exactly 1 entry.
